// File: rtl/fp_add_sub_issue_if.sv
// +---------------------------------------------------------------------------+
// | Module   : fp_add_sub_issue_if                                            |
// | Brief    : Request, adder-unit and response signals of fp_add_sub_issue.  |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

interface fp_add_sub_issue_if #(
  parameter int Size = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_sub;
  logic [2:0]      req_rm;
  logic [Size-1:0] req_a;
  logic [Size-1:0] req_b;
  logic [2:0]      frm;

  logic            fu_start;
  logic            fu_sub;
  logic [2:0]      fu_rounding_mode;
  logic [Size-1:0] fu_operand_a;
  logic [Size-1:0] fu_operand_b;
  logic [Size-1:0] fu_result;
  logic            fu_overflow;
  logic            fu_inexact;
  logic            fu_underflow;
  logic            fu_invalid;
  logic            fu_done;

  logic            resp_valid;
  logic            resp_ready;
  logic [Size-1:0] resp_result;
  logic [4:0]      resp_fflags;
  logic            resp_rm_illegal;
  logic            resp_timeout;
  logic            busy;

  // Issue-logic side.
  modport slave (
    input  req_valid, req_sub, req_rm, req_a, req_b, frm,
    input  fu_result, fu_overflow, fu_inexact, fu_underflow, fu_invalid, fu_done,
    input  resp_ready,
    output req_ready,
    output fu_start, fu_sub, fu_rounding_mode, fu_operand_a, fu_operand_b,
    output resp_valid, resp_result, resp_fflags, resp_rm_illegal, resp_timeout,
    output busy
  );

  // Requester / adder-unit side.
  modport master (
    output req_valid, req_sub, req_rm, req_a, req_b, frm,
    output fu_result, fu_overflow, fu_inexact, fu_underflow, fu_invalid, fu_done,
    output resp_ready,
    input  req_ready,
    input  fu_start, fu_sub, fu_rounding_mode, fu_operand_a, fu_operand_b,
    input  resp_valid, resp_result, resp_fflags, resp_rm_illegal, resp_timeout,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/fp_add_sub_issue.sv
// +---------------------------------------------------------------------------+
// | Module   : fp_add_sub_issue                                               |
// | Brief    : Issue FSM for an FP add/sub unit: rounding-mode resolution,    |
// |            single-cycle start pulse, result capture and response hold.    |
// |            Optional WAIT watchdog enabled by FP_ADDSUB_TIMEOUT_EN.        |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module fp_add_sub_issue #(
  parameter int Size          = 32,
  parameter int TimeoutCycles = 64
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fp_add_sub_issue_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [Size-1:0] CanonNan = Size'(32'h7FC0_0000);
  localparam logic [2:0]      RmDyn    = 3'b111;
  localparam logic [2:0]      RmMaxOk  = 3'b100;

  state_t          state_q, state_d;
  logic            sub_q, sub_d;
  logic [Size-1:0] a_q, a_d;
  logic [Size-1:0] b_q, b_d;
  logic [2:0]      rm_q, rm_d;
  logic [Size-1:0] result_q, result_d;
  logic [4:0]      fflags_q, fflags_d;
  logic            illegal_q, illegal_d;
  logic            wait_first_q, wait_first_d;
  logic [2:0]      rm_res_w;

`ifdef FP_ADDSUB_TIMEOUT_EN
  localparam int               CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  assign rm_res_w = (bus.req_rm == RmDyn) ? bus.frm : bus.req_rm;

  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    a_d          = a_q;
    b_d          = b_q;
    rm_d         = rm_q;
    result_d     = result_q;
    fflags_d     = fflags_q;
    illegal_d    = illegal_q;
    wait_first_d = 1'b0;
`ifdef FP_ADDSUB_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          sub_d = bus.req_sub;
          a_d   = bus.req_a;
          b_d   = bus.req_b;
          rm_d  = rm_res_w;
          if (rm_res_w > RmMaxOk) begin
            // Reserved rounding mode: answer immediately without starting the unit.
            result_d  = CanonNan;
            fflags_d  = 5'b0;
            illegal_d = 1'b1;
`ifdef FP_ADDSUB_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
            state_d   = ST_RESP;
          end else begin
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        wait_first_d = 1'b1;
`ifdef FP_ADDSUB_TIMEOUT_EN
        cnt_d        = '0;
`endif
        state_d      = ST_WAIT;
      end

      ST_WAIT: begin
`ifdef FP_ADDSUB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // A done still high from the previous operation is masked for one cycle.
        if (!wait_first_q && bus.fu_done) begin
          result_d  = bus.fu_result;
          fflags_d  = {bus.fu_invalid, 1'b0, bus.fu_overflow,
                       bus.fu_underflow, bus.fu_inexact};
          illegal_d = 1'b0;
`ifdef FP_ADDSUB_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = ST_RESP;
        end
`ifdef FP_ADDSUB_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          result_d  = CanonNan;
          fflags_d  = 5'b10000;
          illegal_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end
`endif
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sub_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rm_q         <= 3'b0;
      result_q     <= '0;
      fflags_q     <= 5'b0;
      illegal_q    <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rm_q         <= rm_d;
      result_q     <= result_d;
      fflags_q     <= fflags_d;
      illegal_q    <= illegal_d;
      wait_first_q <= wait_first_d;
    end
  end

`ifdef FP_ADDSUB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.resp_timeout = timeout_q;
`else
  assign bus.resp_timeout = 1'b0;
`endif

  assign bus.req_ready        = (state_q == ST_IDLE) && !reset;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.fu_start         = (state_q == ST_START);
  assign bus.fu_sub           = sub_q;
  assign bus.fu_rounding_mode = rm_q;
  assign bus.fu_operand_a     = a_q;
  assign bus.fu_operand_b     = b_q;
  assign bus.resp_valid       = (state_q == ST_RESP);
  assign bus.resp_result      = result_q;
  assign bus.resp_fflags      = fflags_q;
  assign bus.resp_rm_illegal  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_sub_issue.sv
// +---------------------------------------------------------------------------+
// | Module   : tb_fp_add_sub_issue                                            |
// | Brief    : Self-checking bench for fp_add_sub_issue; the bench plays the  |
// |            requester and the add/sub unit and predicts every response.   |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_fp_add_sub_issue;

  localparam logic [31:0] CanonNan = 32'h7FC0_0000;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fp_add_sub_issue_if #(.Size(32)) bus ();

  fp_add_sub_issue #(
    .Size          (32),
    .TimeoutCycles (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_fu(input logic done, input logic [31:0] res, input logic [3:0] fl);
    bus.fu_done      = done;
    bus.fu_result    = res;
    bus.fu_invalid   = fl[3];
    bus.fu_overflow  = fl[2];
    bus.fu_underflow = fl[1];
    bus.fu_inexact   = fl[0];
  endtask

  // One full transaction, entered and left in IDLE just after a falling edge.
  // fl = {invalid, overflow, underflow, inexact} returned by the unit.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [2:0] rm, input logic [2:0] frm_v, input int dly,
                       input logic [31:0] res, input logic [3:0] fl, input int hold,
                       input bit stale);
    logic [2:0]  mode;
    bit          legal;
    logic [31:0] exp_res;
    logic [4:0]  exp_fl;

    mode    = (rm == 3'b111) ? frm_v : rm;
    legal   = (mode <= 3'd4);
    exp_res = legal ? res : CanonNan;
    exp_fl  = legal ? {fl[3], 1'b0, fl[2], fl[1], fl[0]} : 5'b0;

    check("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sub   = sub;
    bus.req_rm    = rm;
    bus.frm       = frm_v;
    if (stale) set_fu(1'b1, 32'hBAD0_0BAD, 4'hF);
    else       set_fu(1'b0, 32'h0, 4'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;

    if (!legal) begin
      check("illegal_no_start", {31'b0, bus.fu_start}, 32'd0);
      check("illegal_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
      check("illegal_flag", {31'b0, bus.resp_rm_illegal}, 32'd1);
    end else begin
      check("start_pulse", {31'b0, bus.fu_start}, 32'd1);
      check("start_rm", {29'b0, bus.fu_rounding_mode}, {29'b0, mode});
      check("start_opa", bus.fu_operand_a, a);
      check("start_opb", bus.fu_operand_b, b);
      check("start_sub", {31'b0, bus.fu_sub}, {31'b0, sub});
      check("start_busy", {31'b0, bus.busy}, 32'd1);
      check("start_req_ready", {31'b0, bus.req_ready}, 32'd0);
      check("start_no_resp", {31'b0, bus.resp_valid}, 32'd0);
      @(negedge clk);
      for (int k = 1; k <= dly; k++) begin
        check("wait_no_resp", {31'b0, bus.resp_valid}, 32'd0);
        check("wait_no_start", {31'b0, bus.fu_start}, 32'd0);
        if (k == dly)               set_fu(1'b1, res, fl);
        else if (stale && k == 1)   set_fu(1'b1, 32'hBAD0_0BAD, 4'hF);
        else                        set_fu(1'b0, 32'h0, 4'h0);
        @(negedge clk);
      end
      set_fu(1'b0, 32'h0, 4'h0);
      check("resp_valid", {31'b0, bus.resp_valid}, 32'd1);
      check("resp_not_illegal", {31'b0, bus.resp_rm_illegal}, 32'd0);
    end

    check("resp_result", bus.resp_result, exp_res);
    check("resp_fflags", {27'b0, bus.resp_fflags}, {27'b0, exp_fl});
    check("resp_timeout", {31'b0, bus.resp_timeout}, 32'd0);

    for (int h = 0; h < hold; h++) begin
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_a      = ~a;
      bus.req_rm     = 3'b000;
      check("hold_valid", {31'b0, bus.resp_valid}, 32'd1);
      check("hold_result", bus.resp_result, exp_res);
      check("hold_fflags", {27'b0, bus.resp_fflags}, {27'b0, exp_fl});
      check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
      check("hold_opa", bus.fu_operand_a, a);
      @(negedge clk);
    end

    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_a      = ~a;
    bus.req_rm     = 3'b000;
    check("hs_valid", {31'b0, bus.resp_valid}, 32'd1);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    check("post_hs_no_resp", {31'b0, bus.resp_valid}, 32'd0);
    check("post_hs_busy", {31'b0, bus.busy}, 32'd0);
    check("post_hs_no_start", {31'b0, bus.fu_start}, 32'd0);
    check("post_hs_opa_kept", bus.fu_operand_a, a);
  endtask

  task automatic reset_in_wait();
    bus.req_valid = 1'b1;
    bus.req_a     = 32'h1234_5678;
    bus.req_b     = 32'h9ABC_DEF0;
    bus.req_sub   = 1'b1;
    bus.req_rm    = 3'b001;
    set_fu(1'b0, 32'h0, 4'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_busy", {31'b0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_opa_clear", bus.fu_operand_a, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    set_fu(1'b1, 32'hCAFE_F00D, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_late_done_no_resp", {31'b0, bus.resp_valid}, 32'd0);
      check("rst_late_done_idle", {31'b0, bus.busy}, 32'd0);
    end
    set_fu(1'b0, 32'h0, 4'h0);
    check("rst_after_ready", {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_sub    = 1'b0;
    bus.req_rm     = 3'b0;
    bus.req_a      = 32'h0;
    bus.req_b      = 32'h0;
    bus.frm        = 3'b0;
    bus.resp_ready = 1'b0;
    set_fu(1'b0, 32'h0, 4'h0);

    #2;
    check("reset_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("reset_fu_start", {31'b0, bus.fu_start}, 32'd0);
    check("reset_result", bus.resp_result, 32'd0);
    check("reset_fflags", {27'b0, bus.resp_fflags}, 32'd0);
    check("reset_illegal", {31'b0, bus.resp_rm_illegal}, 32'd0);
    check("reset_opa", bus.fu_operand_a, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_ready", {31'b0, bus.req_ready}, 32'd1);

    // 1.0 + 2.0 = 3.0 with the unit answering after 5 cycles.
    do_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'b000, 3'b000, 5,
          32'h4040_0000, 4'h0, 0, 1'b0);
    do_op(32'h3F80_0000, 32'h4000_0000, 1'b1, 3'b111, 3'b010, 3,
          32'hBF80_0000, 4'b0001, 1, 1'b0);
    do_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'b111, 3'b101, 3,
          32'h0, 4'h0, 1, 1'b0);
    do_op(32'h7F80_0000, 32'h7F80_0000, 1'b1, 3'b110, 3'b000, 3,
          32'h0, 4'h0, 0, 1'b0);
    do_op(32'h4120_0000, 32'h4120_0000, 1'b0, 3'b011, 3'b000, 4,
          32'h41A0_0000, 4'b1010, 10, 1'b0);
    do_op(32'h4000_0000, 32'h4000_0000, 1'b0, 3'b100, 3'b000, 2,
          32'h4080_0000, 4'b0101, 0, 1'b1);
    // No watchdog in this build: a very slow unit must still be waited for.
    do_op(32'h3F00_0000, 32'h3F00_0000, 1'b0, 3'b001, 3'b000, 80,
          32'h3F80_0000, 4'h0, 0, 1'b0);

    reset_in_wait();

    for (int n = 0; n < 40; n++) begin
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), $urandom_range(2, 7), $urandom,
            4'($urandom_range(0, 15)), $urandom_range(0, 3), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

`default_nettype wire
